l0_loader: RTL and testbench

//  Upstream feeder for the L0 row buffer in front of the MAC array. On start, streams num_vec

---
 rtl/l0_loader.sv | 185 ++++++++++++++++++
 tb/tb_l0_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/l0_loader.sv
// Streams num_vec consecutive SRAM words into the L0 row buffer through a 2-entry skid buffer.
// Optional stall counter output enabled by defining L0_LOADER_STALL_CNT_EN.
module l0_loader #(
    parameter int row    = 8,
    parameter int bw     = 4,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    num_vec,
    output logic                busy,
    output logic                done,
    output logic                sram_cen,
    output logic                sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    input  logic [row*bw-1:0]   sram_dout,
    output logic                l0_wr,
    output logic [row*bw-1:0]   l0_data,
    input  logic                l0_ready
`ifdef L0_LOADER_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int W = row * bw;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  written;
    logic              inflight;
    logic [1:0]        skid_cnt;
    logic [W-1:0]      skid_head;
    logic [W-1:0]      skid_tail;

    logic              accept;
    logic              issue;
    logic              push;
    logic              pop;
    logic [2:0]        occupancy;

    assign accept = (state == IDLE) && start;
    assign push   = inflight;
    assign pop    = l0_wr;

    // Slots already committed: buffered words plus the read in flight, less the one leaving now.
    assign occupancy = 3'(skid_cnt) + 3'(inflight) - 3'(l0_wr);

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        issue      = 1'b0;
        sram_cen   = 1'b1;
        sram_wen   = 1'b1;
        sram_addr  = '0;
        l0_wr      = 1'b0;
        l0_data    = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_vec == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (issued == num_q) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (written == num_q) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy = (state != IDLE);
        done = (state == FIN);

        if (skid_cnt != 2'd0) begin
            l0_wr   = l0_ready;
            l0_data = skid_head;
        end

        issue = (state == RUN) && (issued < num_q) && (occupancy < 3'd2);
        if (issue) begin
            sram_cen  = 1'b0;
            sram_addr = base_q + ADDR_W'(issued);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register in this block sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            issued   <= '0;
            written  <= '0;
            inflight <= 1'b0;
            skid_cnt <= 2'd0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            skid_cnt <= skid_cnt + 2'(push) - 2'(pop);
            if (accept) begin
                base_q  <= base_addr;
                num_q   <= num_vec;
                issued  <= '0;
                written <= '0;
            end else begin
                if (issue) begin
                    issued <= issued + 1'b1;
                end
                if (pop) begin
                    written <= written + 1'b1;
                end
            end
        end
    end

    // NOTE: the skid data registers are deliberately not reset; skid_cnt gates every read of them,
    // so stale contents are never visible and the wide datapath stays free of reset fan-out.
    always_ff @(posedge clk) begin
        case ({push, pop})
            2'b10: begin
                if (skid_cnt == 2'd0) begin
                    skid_head <= sram_dout;
                end else begin
                    skid_tail <= sram_dout;
                end
            end
            2'b01: begin
                skid_head <= skid_tail;
            end
            2'b11: begin
                if (skid_cnt == 2'd1) begin
                    skid_head <= sram_dout;
                end else begin
                    skid_head <= skid_tail;
                    skid_tail <= sram_dout;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef L0_LOADER_STALL_CNT_EN
    // Cycles where a word is ready but L0 refuses it; saturating, kept after done for readout.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (accept) begin
            stall_cnt <= 16'd0;
        end else if (busy && (skid_cnt != 2'd0) && !l0_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l0_loader.sv
// Directed table-driven bench for l0_loader with a behavioural 1-cycle-latency SRAM.
// Define L0_LOADER_STALL_CNT_EN to also check the stall counter.
module tb_l0_loader;

    localparam int ADDR_W = 11;
    localparam int CNT_W  = 12;
    localparam int W      = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_vec;
    logic              busy;
    logic              done;
    logic              sram_cen;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [W-1:0]      sram_dout;
    logic              l0_wr;
    logic [W-1:0]      l0_data;
    logic              l0_ready;
`ifdef L0_LOADER_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    l0_loader #(.row(8), .bw(4), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_vec   (num_vec),
        .busy      (busy),
        .done      (done),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout),
        .l0_wr     (l0_wr),
        .l0_data   (l0_data),
        .l0_ready  (l0_ready)
`ifdef L0_LOADER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Each address holds a distinct, recognisable word.
    function automatic logic [W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[7:0], ~a[7:0], 5'b10101, a};
    endfunction

    always @(posedge clk) begin
        if (!sram_cen) begin
            sram_dout <= mem_word(sram_addr);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [CNT_W-1:0]  num;
        int                stall_lo;
        int                stall_hi;
        int                restart_a;
        int                restart_b;
        int                exp_first_wr;
        int                exp_done;
        int                exp_win_issues;
        logic [ADDR_W-1:0] exp_addr2;
        int                exp_stall;
    } vec_t;

    // Cycle c is the c-th cycle after the edge that accepts start (start is driven in cycle 0).
    task automatic run_xfer(input vec_t v, input string tag);
        int nwr, niss, ndone, done_c, first_wr, nbusy, win_iss;
        logic [ADDR_W-1:0] addr2;
        nwr = 0; niss = 0; ndone = 0; done_c = -1; first_wr = -1; nbusy = 0; win_iss = 0;
        addr2 = '0;
        @(negedge clk);
        start = 1'b1; base_addr = v.base; num_vec = v.num; l0_ready = 1'b1;
        @(negedge clk);
        base_addr = 11'h555; num_vec = 12'd7;
        for (int c = 1; c <= 60; c++) begin
            start    = (c == v.restart_a) || (c == v.restart_b);
            l0_ready = !(c >= v.stall_lo && c <= v.stall_hi);
            #1;
            if (!sram_cen) begin
                check({tag, " addr"}, 64'(sram_addr), 64'(ADDR_W'(v.base + ADDR_W'(niss))));
                if (niss == 2) addr2 = sram_addr;
                if (c >= v.stall_lo && c <= v.stall_hi) win_iss++;
                niss++;
            end
            if (l0_wr) begin
                check({tag, " data"}, 64'(l0_data), 64'(mem_word(ADDR_W'(v.base + ADDR_W'(nwr)))));
                if (first_wr < 0) first_wr = c;
                nwr++;
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c >= done_c + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " writes"}, 64'(nwr), 64'(v.num));
        check({tag, " issues"}, 64'(niss), 64'(v.num));
        check({tag, " done_count"}, 64'(ndone), 64'd1);
        check({tag, " done_cycle"}, 64'(done_c), 64'(v.exp_done));
        check({tag, " first_wr"}, 64'(first_wr), 64'(v.exp_first_wr));
        check({tag, " busy_cycles"}, 64'(nbusy), 64'(v.exp_done));
        check({tag, " stall_issues"}, 64'(win_iss), 64'(v.exp_win_issues));
        if (v.num >= 3) check({tag, " addr2"}, 64'(addr2), 64'(v.exp_addr2));
`ifdef L0_LOADER_STALL_CNT_EN
        check({tag, " stall_cnt"}, 64'(stall_cnt), 64'(v.exp_stall));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " sram_cen"}, 64'(sram_cen), 64'd1);
        check({tag, " sram_wen"}, 64'(sram_wen), 64'd1);
        check({tag, " sram_addr"}, 64'(sram_addr), 64'd0);
        check({tag, " l0_wr"}, 64'(l0_wr), 64'd0);
        check({tag, " l0_data"}, 64'(l0_data), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        int n_done, n_wr, n_iss;

        //          base    num  slo shi ra rb first done win addr2   stall
        vecs[0] = '{11'h010, 12'd4, 0, -1, 0, 0, 3,  8,  0, 11'h012, 0};
        vecs[1] = '{11'h020, 12'd0, 0, -1, 0, 0, -1, 1,  0, 11'h000, 0};
        vecs[2] = '{11'h100, 12'd6, 4,  9, 0, 0, 3,  16, 0, 11'h102, 6};
        vecs[3] = '{11'h7FE, 12'd4, 0, -1, 0, 0, 3,  8,  0, 11'h000, 0};
        vecs[4] = '{11'h3A0, 12'd1, 0, -1, 0, 0, 3,  5,  0, 11'h000, 0};

        reset = 1'b1; start = 1'b0; base_addr = '0; num_vec = '0; l0_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Start pulses while busy (mid-run and in the done cycle) must be ignored.
        v = '{11'h080, 12'd5, 0, -1, 4, 9, 3, 9, 0, 11'h082, 0};
        run_xfer(v, "restart");

        // Reset in cycle 4 of a 10-word transfer aborts it without a done pulse.
        @(negedge clk);
        start = 1'b1; base_addr = 11'h040; num_vec = 12'd10; l0_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("abort");
        reset = 1'b0;
        n_done = 0; n_wr = 0; n_iss = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (done) n_done++;
            if (l0_wr) n_wr++;
            if (!sram_cen) n_iss++;
        end
        check("abort done", 64'(n_done), 64'd0);
        check("abort l0_wr", 64'(n_wr), 64'd0);
        check("abort issues", 64'(n_iss), 64'd0);

        v = '{11'h200, 12'd3, 0, -1, 0, 0, 3, 7, 0, 11'h202, 0};
        run_xfer(v, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
